sram_bus_ctrl: RTL and testbench



---
 rtl/sram_bus_ctrl.sv | 147 ++++++++++++++
 tb/tb_sram_bus_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_ctrl.sv
// Purpose: sequences one CPU read/write into the 32x8 async-handshake SRAM (Address/Write/Start/DataIO/MemDone).
// Latency: accept, SETUP, STROBE, then SRAM time capped at TIMEOUT cycles, then a 1-cycle RESP pulse.
// Backpressure: ReqReady is high only in IDLE (one access in flight); the response pulse cannot be stalled.
//
// Ports:
//   Clk, Reset                    - system clock, synchronous active-high reset
//   ReqValid/ReqReady             - CPU request handshake; ReqWrite/ReqAddr/ReqData sampled at the accept edge
//   RspValid/RspData/RspErr       - one-cycle completion pulse; RspData is 0 for writes and timeouts
//   MemAddress/MemWrite/MemStart  - SRAM controls (Start is posedge-triggered at the SRAM)
//   MemDone                       - SRAM completion, sampled directly on Clk
//   MemDataIO                     - shared SRAM data bus, driven here only during writes
module sram_bus_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic       ReqWrite,
  input  logic [4:0] ReqAddr,
  input  logic [7:0] ReqData,
  output logic       RspValid,
  output logic [7:0] RspData,
  output logic       RspErr,
  output logic [4:0] MemAddress,
  output logic       MemWrite,
  output logic       MemStart,
  input  logic       MemDone,
  inout  wire  [7:0] MemDataIO
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    STROBE    = 3'd2,
    WAIT_LOW  = 3'd3,
    WAIT_DONE = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t        state;
  logic [7:0]    wdata;
  logic          drv_en;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  // The counter is cleared on WAIT_LOW entry and read before its increment,
  // so the registered value lags the cycles already waited by one. Comparing
  // against TIMEOUT-1 therefore aborts after exactly TIMEOUT waiting cycles.
  // ">=" covers the case where WAIT_LOW exits on the final edge and WAIT_DONE
  // starts with the count already at the limit.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  assign tmo_hit   = (tmo_cnt >= TMO_LAST);
  assign MemDataIO = drv_en ? wdata : 8'bz;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ReqReady   <= 1'b1;
      RspValid   <= 1'b0;
      RspData    <= 8'h00;
      RspErr     <= 1'b0;
      MemAddress <= 5'd0;
      MemWrite   <= 1'b0;
      MemStart   <= 1'b0;
      wdata      <= 8'h00;
      drv_en     <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      RspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (ReqValid && ReqReady) begin
            MemAddress <= ReqAddr;
            MemWrite   <= ReqWrite;
            wdata      <= ReqData;
            // Drive write data from SETUP onward; the SRAM captures it at posedge Start.
            drv_en     <= ReqWrite;
            ReqReady   <= 1'b0;
            state      <= SETUP;
          end
        end

        SETUP: begin
          MemStart <= 1'b0;
          state    <= STROBE;
        end

        STROBE: begin
          MemStart <= 1'b1;
          tmo_cnt  <= '0;
          state    <= WAIT_LOW;
        end

        WAIT_LOW: begin
          // MemDone low proves the SRAM took Start; this also masks its power-up MemDone=1.
          if (!MemDone) begin
            MemStart <= 1'b0;
            tmo_cnt  <= tmo_cnt + TW'(1);
            state    <= WAIT_DONE;
          end else if (tmo_hit) begin
            MemStart <= 1'b0;
            drv_en   <= 1'b0;
            RspErr   <= 1'b1;
            RspData  <= 8'h00;
            RspValid <= 1'b1;
            state    <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        WAIT_DONE: begin
          // A completing MemDone wins over a timeout landing on the same edge.
          if (MemDone) begin
            RspData  <= MemWrite ? 8'h00 : MemDataIO;
            RspErr   <= 1'b0;
            RspValid <= 1'b1;
            drv_en   <= 1'b0;
            state    <= RESP;
          end else if (tmo_hit) begin
            RspErr   <= 1'b1;
            RspData  <= 8'h00;
            RspValid <= 1'b1;
            drv_en   <= 1'b0;
            state    <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        RESP: begin
          MemStart <= 1'b0;
          ReqReady <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Purpose: self-checking bench for sram_bus_ctrl with a behavioural async-handshake SRAM.
// Latency: checks response arrival cycle, Start timing and the write-data drive window per access.
// Backpressure: exercises ReqValid held high while ReqReady is low and back-to-back accesses.
module tb_sram_bus_ctrl;

  localparam int TIMEOUT = 15;
  localparam int NEVER   = 1000;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       ReqValid;
  logic       ReqReady;
  logic       ReqWrite;
  logic [4:0] ReqAddr;
  logic [7:0] ReqData;
  logic       RspValid;
  logic [7:0] RspData;
  logic       RspErr;
  logic [4:0] MemAddress;
  logic       MemWrite;
  logic       MemStart;
  logic       mem_done;
  wire  [7:0] MemDataIO;

  // SRAM model state
  logic [7:0] sram_mem [32];
  logic [7:0] sram_q;
  logic       sram_oe;
  bit         sram_busy;
  int         sram_lat;

  // Reference memory contents as seen by the CPU
  logic [7:0] ref_mem [32];

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    bit         w;
    logic [4:0] a;
    logic [7:0] d;
    int         lat;
    bit         e_err;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl [10];

  assign MemDataIO = sram_oe ? sram_q : 8'bz;

  always #5 Clk = ~Clk;

  sram_bus_ctrl #(.TIMEOUT(TIMEOUT), .TW(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqWrite   (ReqWrite),
    .ReqAddr    (ReqAddr),
    .ReqData    (ReqData),
    .RspValid   (RspValid),
    .RspData    (RspData),
    .RspErr     (RspErr),
    .MemAddress (MemAddress),
    .MemWrite   (MemWrite),
    .MemStart   (MemStart),
    .MemDone    (mem_done),
    .MemDataIO  (MemDataIO)
  );

  // Behavioural SRAM: captures address/write/data at posedge Start, drops MemDone
  // shortly after, then raises it for one clock sram_lat clocks later (never if NEVER).
  initial begin
    logic [4:0] a;
    bit         w;
    for (int i = 0; i < 32; i++) sram_mem[i] = 8'h00;
    mem_done  = 1'b1;
    sram_oe   = 1'b0;
    sram_q    = 8'h00;
    sram_busy = 1'b0;
    forever begin
      @(posedge MemStart);
      sram_busy = 1'b1;
      a = MemAddress;
      w = MemWrite;
      if (w) sram_mem[a] = MemDataIO;
      #1 mem_done = 1'b0;
      if (sram_lat < NEVER) begin
        repeat (sram_lat) @(posedge Clk);
        #1;
        if (!w) begin
          sram_q  = sram_mem[a];
          sram_oe = 1'b1;
        end
        mem_done = 1'b1;
        @(posedge Clk);
        #1;
        mem_done = 1'b0;
        sram_oe  = 1'b0;
      end
      sram_busy = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ":outs"},
        32'({ReqReady, RspValid, RspErr, MemStart, MemWrite, MemAddress, RspData}),
        32'({1'b1, 17'd0}));
    chk({tag, ":drv"}, 32'(dut.drv_en), 32'd0);
  endtask

  task automatic wait_sram_idle();
    int n;
    n = 0;
    while (sram_busy && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("sram_idle", 32'(sram_busy), 32'd0);
    @(posedge Clk);
    #1;
  endtask

  // One complete access: issue, follow it cycle by cycle, check the response.
  task automatic do_access(input bit w, input logic [4:0] a, input logic [7:0] d,
                           input int lat, input bit e_err, input logic [7:0] e_data,
                           input string tag);
    int n;
    int start_n;
    int exp_n;
    bit drv_ok;
    bit got;
    sram_lat = lat;
    exp_n    = e_err ? TIMEOUT + 2 : lat + 3;
    n = 0;
    while (!ReqReady && n < 50) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk({tag, ":ready"}, 32'(ReqReady), 32'd1);
    ReqValid = 1'b1;
    ReqWrite = w;
    ReqAddr  = a;
    ReqData  = d;
    @(posedge Clk);
    #1;
    // Fields only need to be stable at the accept edge.
    ReqValid = 1'b0;
    ReqWrite = 1'($urandom);
    ReqAddr  = 5'($urandom);
    ReqData  = 8'($urandom);
    n = 0;
    start_n = -1;
    drv_ok  = 1'b1;
    got     = 1'b0;
    while (n < 60) begin
      if (start_n < 0 && MemStart) start_n = n;
      if (RspValid) begin
        got = 1'b1;
        break;
      end
      if (w) begin
        if (!(dut.drv_en === 1'b1 && MemDataIO === d)) drv_ok = 1'b0;
      end else if (dut.drv_en !== 1'b0) begin
        drv_ok = 1'b0;
      end
      @(posedge Clk);
      #1;
      n++;
    end
    chk({tag, ":rsp_seen"}, 32'(got), 32'd1);
    chk({tag, ":rsp_cycle"}, 32'(n), 32'(exp_n));
    chk({tag, ":err"}, 32'(RspErr), 32'(e_err));
    chk({tag, ":data"}, 32'(RspData), 32'(e_data));
    chk({tag, ":start_cycle"}, 32'(start_n), 32'd2);
    chk({tag, ":bus_drive"}, 32'(drv_ok), 32'd1);
    chk({tag, ":rsp_drv_off"}, 32'(dut.drv_en), 32'd0);
    @(posedge Clk);
    #1;
    chk({tag, ":pulse_1cyc"}, 32'({RspValid, ReqReady}), 32'b01);
    chk({tag, ":err_hold"}, 32'({RspErr, RspData}), 32'({e_err, e_data}));
    wait_sram_idle();
  endtask

  initial begin
    bit         w;
    logic [4:0] a;
    logic [7:0] d;
    int         lat;
    int         r;
    bit         e_err;
    logic [7:0] e_data;
    bit         bw [3];
    logic [4:0] ba [3];
    logic [7:0] bd [3];
    logic [8:0] got_q [$];
    int         acc_cyc [3];
    int         idx;
    int         rsp;
    int         bad_rdy;
    int         cyc;
    int         extra;
    bit         rdy_prev;

    // {write, addr, data, sram latency, expected err, expected data}
    tbl[0] = '{1'b1, 5'd3,  8'hA5, 3,     1'b0, 8'h00};  // write then verify later
    tbl[1] = '{1'b0, 5'd3,  8'h00, 3,     1'b0, 8'hA5};
    tbl[2] = '{1'b1, 5'd31, 8'h5A, 1,     1'b0, 8'h00};  // top address, fastest SRAM
    tbl[3] = '{1'b0, 5'd31, 8'h00, 14,    1'b0, 8'h5A};  // MemDone on the timeout edge wins
    tbl[4] = '{1'b0, 5'd3,  8'h00, 15,    1'b1, 8'h00};  // one cycle too late
    tbl[5] = '{1'b1, 5'd7,  8'h3C, NEVER, 1'b1, 8'h00};  // MemDone never returns
    tbl[6] = '{1'b0, 5'd7,  8'h00, 1,     1'b0, 8'h3C};  // recovery; SRAM took data at Start
    tbl[7] = '{1'b0, 5'd3,  8'h00, 2,     1'b0, 8'hA5};
    tbl[8] = '{1'b1, 5'd0,  8'h00, 6,     1'b0, 8'h00};
    tbl[9] = '{1'b0, 5'd0,  8'h00, 6,     1'b0, 8'h00};

    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    sram_lat = 3;
    Reset    = 1'b1;
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    ReqAddr  = 5'd0;
    ReqData  = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    chk_reset_outs("reset");
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Table-driven accesses
    for (int i = 0; i < 10; i++) begin
      do_access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].lat, tbl[i].e_err, tbl[i].e_data,
                $sformatf("tbl%0d", i));
      if (tbl[i].w) ref_mem[tbl[i].a] = tbl[i].d;
    end
    chk("sram_mem3", 32'(sram_mem[3]), 32'hA5);

    // Back-to-back with ReqValid held high across not-ready cycles
    bw[0] = 1'b1; ba[0] = 5'd0;  bd[0] = 8'h11;
    bw[1] = 1'b0; ba[1] = 5'd0;  bd[1] = 8'h00;
    bw[2] = 1'b1; ba[2] = 5'd31; bd[2] = 8'hFF;
    sram_lat = 2;
    idx = 0; rsp = 0; bad_rdy = 0; cyc = 0; extra = 0;
    ReqValid = 1'b1; ReqWrite = bw[0]; ReqAddr = ba[0]; ReqData = bd[0];
    rdy_prev = ReqReady;
    while ((idx < 3 || rsp < 3) && cyc < 150) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (ReqValid && rdy_prev) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) begin
          ReqWrite = bw[idx]; ReqAddr = ba[idx]; ReqData = bd[idx];
        end else begin
          ReqValid = 1'b0;
        end
      end
      if (RspValid) begin
        got_q.push_back({RspErr, RspData});
        rsp++;
      end
      if (ReqReady !== ((idx == rsp) && !RspValid)) bad_rdy++;
      rdy_prev = ReqReady;
    end
    repeat (10) begin
      @(posedge Clk);
      #1;
      if (RspValid) extra++;
    end
    chk("b2b:accepts", 32'(idx), 32'd3);
    chk("b2b:responses", 32'(got_q.size()), 32'd3);
    chk("b2b:ready_only_idle", 32'(bad_rdy), 32'd0);
    chk("b2b:no_extra_rsp", 32'(extra), 32'd0);
    if (got_q.size() == 3) begin
      chk("b2b:rsp0", 32'(got_q[0]), 32'h000);
      chk("b2b:rsp1", 32'(got_q[1]), 32'h011);
      chk("b2b:rsp2", 32'(got_q[2]), 32'h000);
    end
    if (idx == 3) chk("b2b:min_gap", 32'((acc_cyc[1] - acc_cyc[0] >= 6) && (acc_cyc[2] - acc_cyc[1] >= 6)), 32'd1);
    chk("b2b:sram_mem31", 32'(sram_mem[31]), 32'hFF);
    ref_mem[0]  = 8'h11;
    ref_mem[31] = 8'hFF;
    wait_sram_idle();

    // Reset in WAIT_DONE of a read; the late MemDone must be ignored
    do_access(1'b1, 5'd9, 8'h77, 2, 1'b0, 8'h00, "rst_pre_w");
    do_access(1'b0, 5'd9, 8'h00, 2, 1'b0, 8'h77, "rst_pre_r");
    ref_mem[9] = 8'h77;
    sram_lat = 6;
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 5'd9;
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("rst_mid:in_wait_done", 32'({MemStart, ReqReady, RspValid}), 32'd0);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk_reset_outs("rst_mid");
    Reset = 1'b0;
    extra = 0;
    repeat (14) begin
      @(posedge Clk);
      #1;
      if (RspValid) extra++;
    end
    chk("rst_mid:no_rsp", 32'(extra), 32'd0);
    wait_sram_idle();
    do_access(1'b0, 5'd9, 8'h00, 4, 1'b0, 8'h77, "rst_post_r");

    // Randomized accesses against the reference memory
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 31));
      d = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      lat = TIMEOUT + $urandom_range(0, 3);
      else if (r == 1) lat = NEVER;
      else             lat = $urandom_range(1, TIMEOUT - 1);
      // MemDone must be seen within TIMEOUT waiting cycles; reads return stored data.
      e_err  = (lat >= TIMEOUT);
      e_data = (w || e_err) ? 8'h00 : ref_mem[a];
      do_access(w, a, d, lat, e_err, e_data, $sformatf("rnd%0d", i));
      if (w) ref_mem[a] = d;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
